// File: rtl/activation_unit.sv
// -----------------------------------------------------------------------------
// activation_unit
//
// Purpose:
//   Requantizes a stream of signed accumulator partial sums into 8-bit
//   activations. Each beat has a per-channel bias added, is rounded (half up)
//   and arithmetically right-shifted, and is then clamped. With ReLU enabled
//   the output is an unsigned byte in [0, 255]. With ReLU disabled it is a
//   signed byte in [-128, 127]. Each beat also gets a buffer address,
//   base + in-frame index, which wraps modulo 1024.
//
//   Beats are grouped into frames, and psum_last_i closes a frame. The
//   bias/shift/relu/base configuration is captured on the first beat of a
//   frame and held for the rest of that frame. There is no backpressure.
//   A beat's result appears exactly two cycles after the cycle in which the
//   beat was presented.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset
//   psum_valid_i         input beat qualifier
//   psum_i               signed partial sum (PSUM_W bits)
//   psum_last_i          last beat of a frame (valid with psum_valid_i)
//   bias_i               signed 16-bit per-channel bias
//   shift_i              unsigned requantization shift amount
//   relu_en_i            1: ReLU / unsigned byte, 0: signed byte
//   base_addr_i          address of the first beat of a frame
//   act_valid_o          output beat qualifier
//   act_result_o         requantized 8-bit activation
//   act_result_address_o buffer address of act_result_o
//   act_last_o           last beat of a frame (only with act_valid_o)
// -----------------------------------------------------------------------------
module activation_unit #(
  parameter int PSUM_W  = 32,
  parameter int SHIFT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     psum_valid_i,
  input  logic signed [PSUM_W-1:0] psum_i,
  input  logic                     psum_last_i,
  input  logic signed [15:0]       bias_i,
  input  logic [SHIFT_W-1:0]       shift_i,
  input  logic                     relu_en_i,
  input  logic [9:0]               base_addr_i,
  output logic                     act_valid_o,
  output logic [7:0]               act_result_o,
  output logic [9:0]               act_result_address_o,
  output logic                     act_last_o
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  // Rounded value width: the sum needs PSUM_W+1 bits, and adding the rounding
  // constant can carry into one more bit.
  localparam int RW = PSUM_W + 2;

  localparam logic signed [RW-1:0] C_U8_MAX = RW'(255);
  localparam logic signed [RW-1:0] C_S8_MAX = RW'(127);
  localparam logic signed [RW-1:0] C_S8_MIN = RW'(-128);

  // Frame control and latched per-frame configuration
  state_t              r_state;
  logic signed [15:0]  r_bias;
  logic [SHIFT_W-1:0]  r_shift;
  logic                r_relu;
  logic [9:0]          r_base;
  logic [9:0]          r_idx;

  // Pipeline stage 1
  logic                r_s1_valid;
  logic signed [PSUM_W:0] r_s1_sum;
  logic [SHIFT_W-1:0]  r_s1_shift;
  logic                r_s1_relu;
  logic [9:0]          r_s1_addr;
  logic                r_s1_last;

  // Pipeline stage 2 (output registers)
  logic                r_act_valid;
  logic [7:0]          r_act_result;
  logic [9:0]          r_act_addr;
  logic                r_act_last;

  // Effective configuration for the beat on the inputs. In IDLE the incoming
  // beat opens a frame, so it uses the live inputs, which are latched on the
  // same edge. In BUSY the latched copy is used.
  logic                w_idle;
  logic signed [15:0]  w_bias;
  logic [SHIFT_W-1:0]  w_shift;
  logic                w_relu;
  logic [9:0]          w_base;
  logic [9:0]          w_idx;
  logic [9:0]          w_addr;
  logic signed [PSUM_W:0] w_sum;

  assign w_idle  = (r_state == S_IDLE);
  assign w_bias  = w_idle ? bias_i      : r_bias;
  assign w_shift = w_idle ? shift_i     : r_shift;
  assign w_relu  = w_idle ? relu_en_i   : r_relu;
  assign w_base  = w_idle ? base_addr_i : r_base;
  assign w_idx   = w_idle ? 10'd0       : r_idx;
  // The 10-bit add wraps from 1023 to 0 by design.
  assign w_addr  = w_base + w_idx;
  // Sign-extend both operands to PSUM_W+1 bits so the add cannot overflow.
  assign w_sum   = {psum_i[PSUM_W-1], psum_i} + {{(PSUM_W-15){w_bias[15]}}, w_bias};

  // Frame FSM, configuration latch and in-frame index
  // NOTE: sequential state is assigned with non-blocking (<=) so that every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bias  <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
      r_base  <= '0;
      r_idx   <= '0;
    end else if (psum_valid_i) begin
      if (w_idle) begin
        r_bias  <= bias_i;
        r_shift <= shift_i;
        r_relu  <= relu_en_i;
        r_base  <= base_addr_i;
      end
      if (psum_last_i) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
      end else begin
        r_state <= S_BUSY;
        r_idx   <= w_idx + 10'd1;
      end
    end
  end

  // Stage 1: bias add and capture of the per-beat configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_shift <= '0;
      r_s1_relu  <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= psum_valid_i;
      if (psum_valid_i) begin
        r_s1_sum   <= w_sum;
        r_s1_shift <= w_shift;
        r_s1_relu  <= w_relu;
        r_s1_addr  <= w_addr;
        r_s1_last  <= psum_last_i;
      end
    end
  end

  // Stage 2 combinational part: round half up, shift, saturate
  logic signed [RW-1:0] w_ext;
  logic signed [RW-1:0] w_half;
  logic signed [RW-1:0] w_rnd;
  logic [7:0]           w_sat;

  assign w_ext = {r_s1_sum[PSUM_W], r_s1_sum};

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_half = '0;
    w_rnd  = w_ext;
    if (r_s1_shift != '0) begin
      w_half = RW'(1) <<< (r_s1_shift - SHIFT_W'(1));
      w_rnd  = (w_ext + w_half) >>> r_s1_shift;
    end
  end

  always_comb begin
    w_sat = w_rnd[7:0];
    if (r_s1_relu) begin
      if (w_rnd < 0)             w_sat = 8'd0;
      else if (w_rnd > C_U8_MAX) w_sat = 8'd255;
    end else begin
      if (w_rnd < C_S8_MIN)      w_sat = 8'h80;
      else if (w_rnd > C_S8_MAX) w_sat = 8'h7F;
    end
  end

  // Stage 2 registers. Result and address hold their value between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_valid  <= 1'b0;
      r_act_result <= '0;
      r_act_addr   <= '0;
      r_act_last   <= 1'b0;
    end else begin
      r_act_valid <= r_s1_valid;
      r_act_last  <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        r_act_result <= w_sat;
        r_act_addr   <= r_s1_addr;
      end
    end
  end

  // The qualifiers are also masked while rst is high. Otherwise the beat
  // already sitting in the output register during the reset cycle would be
  // presented even though the reset is dropping its frame.
  assign act_valid_o          = r_act_valid & ~rst;
  assign act_last_o           = r_act_last & ~rst;
  assign act_result_o         = r_act_result;
  assign act_result_address_o = r_act_addr;

endmodule

// File: tb/tb_activation_unit.sv
// -----------------------------------------------------------------------------
// tb_activation_unit
//
// Self-checking bench for activation_unit. The bench drives single-beat
// requantization vectors from a table and then runs hand-written multi-beat
// frame sequences: back-to-back frames, bubbles with address wrap, config
// changes in mid-frame, and a reset in mid-frame. A monitor records every
// act_valid_o beat together with its cycle number. Expected beats, including
// their exact output cycle, are queued when the stimulus is driven and are
// compared after each sequence.
// -----------------------------------------------------------------------------
module tb_activation_unit;

  logic              clk = 1'b0;
  logic              rst;
  logic              psum_valid_i;
  logic signed [31:0] psum_i;
  logic              psum_last_i;
  logic signed [15:0] bias_i;
  logic [4:0]        shift_i;
  logic              relu_en_i;
  logic [9:0]        base_addr_i;
  logic              act_valid_o;
  logic [7:0]        act_result_o;
  logic [9:0]        act_result_address_o;
  logic              act_last_o;

  activation_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .psum_valid_i         (psum_valid_i),
    .psum_i               (psum_i),
    .psum_last_i          (psum_last_i),
    .bias_i               (bias_i),
    .shift_i              (shift_i),
    .relu_en_i            (relu_en_i),
    .base_addr_i          (base_addr_i),
    .act_valid_o          (act_valid_o),
    .act_result_o         (act_result_o),
    .act_result_address_o (act_result_address_o),
    .act_last_o           (act_last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] psum;
    logic signed [15:0] bias;
    logic [4:0]         shift;
    logic               relu;
    logic [7:0]         exp_res;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] res;
    logic [9:0] addr;
    logic       last;
  } beat_t;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  vec_t  vt[14];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (act_valid_o)
      got_q.push_back('{cyc, act_result_o, act_result_address_o, act_last_o});
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic idle(input int n);
    psum_valid_i = 1'b0;
    psum_last_i  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one beat for one cycle. When expect_out is set, the beat's output
  // is expected two cycles later.
  task automatic beat(input logic signed [31:0] psum, input logic last,
                      input logic signed [15:0] bias, input logic [4:0] shift,
                      input logic relu, input logic [9:0] base,
                      input logic [7:0] e_res, input logic [9:0] e_addr,
                      input bit expect_out);
    psum_valid_i = 1'b1;
    psum_i       = psum;
    psum_last_i  = last;
    bias_i       = bias;
    shift_i      = shift;
    relu_en_i    = relu;
    base_addr_i  = base;
    if (expect_out) exp_q.push_back('{cyc + 2, e_res, e_addr, last});
    @(posedge clk);
    #1;
  endtask

  task automatic drain_compare(input string tag);
    int n;
    idle(4);
    check($sformatf("%s.count", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d].cycle", tag, i), got_q[i].cyc,  exp_q[i].cyc);
      check($sformatf("%s[%0d].result", tag, i), {24'd0, got_q[i].res}, {24'd0, exp_q[i].res});
      check($sformatf("%s[%0d].addr", tag, i), {22'd0, got_q[i].addr}, {22'd0, exp_q[i].addr});
      check($sformatf("%s[%0d].last", tag, i), {31'd0, got_q[i].last}, {31'd0, exp_q[i].last});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Single-beat requantization vectors: psum, bias, shift, relu, expected.
    vt[0]  = '{32'sd1000, 16'sd24, 5'd2, 1'b1, 8'd255}; // 1026>>2=256 -> 255
    vt[1]  = '{32'sd20,   16'sd0,  5'd3, 1'b1, 8'd3};   // (20+4)>>3
    vt[2]  = '{-32'sd50,  16'sd0,  5'd0, 1'b1, 8'd0};   // ReLU clamps negatives
    vt[3]  = '{-32'sd50,  16'sd0,  5'd0, 1'b0, 8'hCE};
    vt[4]  = '{-32'sd300, 16'sd0,  5'd0, 1'b0, 8'h80};
    vt[5]  = '{32'sd300,  16'sd0,  5'd0, 1'b0, 8'h7F};
    vt[6]  = '{-32'sd6,   16'sd0,  5'd2, 1'b0, 8'hFF};  // -1.5 rounds up to -1
    vt[7]  = '{32'sd5,    16'sd0,  5'd1, 1'b0, 8'd3};   // 2.5 rounds up to 3
    vt[8]  = '{32'sd100, -16'sd200, 5'd0, 1'b1, 8'd0};  // negative bias
    vt[9]  = '{32'sd127,  16'sd1,  5'd0, 1'b0, 8'h7F};  // 128 clamps to 127
    vt[10] = '{32'sh7FFFFFFF, 16'sh7FFF, 5'd0,  1'b0, 8'h7F};
    vt[11] = '{32'sh7FFFFFFF, 16'sh7FFF, 5'd31, 1'b1, 8'd1};  // 1.5000.. -> 1
    vt[12] = '{32'sh80000000, -16'sd32768, 5'd0,  1'b0, 8'h80};
    vt[13] = '{32'sh80000000, -16'sd32768, 5'd31, 1'b0, 8'hFF}; // -0.50001 -> -1

    rst          = 1'b1;
    psum_valid_i = 1'b0;
    psum_i       = '0;
    psum_last_i  = 1'b0;
    bias_i       = '0;
    shift_i      = '0;
    relu_en_i    = 1'b0;
    base_addr_i  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.valid",  {31'd0, act_valid_o}, 32'd0);
    check("reset.last",   {31'd0, act_last_o}, 32'd0);
    check("reset.result", {24'd0, act_result_o}, 32'd0);
    check("reset.addr",   {22'd0, act_result_address_o}, 32'd0);
    rst = 1'b0;
    idle(1);

    // Table: back-to-back single-beat frames, each with its own base address.
    for (int i = 0; i < 14; i++)
      beat(vt[i].psum, 1'b1, vt[i].bias, vt[i].shift, vt[i].relu,
           10'(10 + i), vt[i].exp_res, 10'(10 + i), 1'b1);
    drain_compare("table");

    // 16-beat frame at base 1, back to back: results k, addresses 1..16.
    for (int k = 1; k <= 16; k++)
      beat(32'(4 * k), (k == 16), 16'sd0, 5'd2, 1'b1, 10'd1,
           8'(k), 10'(k), 1'b1);
    drain_compare("frame16");

    // Wrap with bubbles: base 1020, 6 beats -> 1020..1023, 0, 1.
    for (int k = 0; k < 6; k++) begin
      beat(32'(100 + k), (k == 5), 16'sd0, 5'd0, 1'b1, 10'd1020,
           8'(100 + k), 10'(1020 + k), 1'b1);
      if (k < 5) idle(1 + (k % 2));
    end
    drain_compare("wrap");
    check("hold.result", {24'd0, act_result_o}, 32'd105);
    check("hold.addr",   {22'd0, act_result_address_o}, 32'd1);

    // Config isolation: beats 3 and 4 present new config, which is ignored.
    // Frame B follows back to back and uses the new config.
    beat(32'sd20, 1'b0, 16'sd0,  5'd1, 1'b1, 10'd200, 8'd10, 10'd200, 1'b1);
    beat(32'sd40, 1'b0, 16'sd0,  5'd1, 1'b1, 10'd200, 8'd20, 10'd201, 1'b1);
    beat(32'sd60, 1'b0, 16'sd50, 5'd3, 1'b0, 10'd500, 8'd30, 10'd202, 1'b1);
    beat(32'sd80, 1'b1, 16'sd50, 5'd3, 1'b0, 10'd500, 8'd40, 10'd203, 1'b1);
    beat(32'sd80,  1'b0, 16'sd0, 5'd3, 1'b1, 10'd500, 8'd10, 10'd500, 1'b1);
    beat(32'sd160, 1'b1, 16'sd0, 5'd3, 1'b1, 10'd500, 8'd20, 10'd501, 1'b1);
    drain_compare("cfg");

    // Reset in mid-frame: beats 1..5 of a 16-beat frame at base 300. Only
    // beats 1..3 reach the output. Beats 4 and 5 are dropped by the reset.
    for (int k = 1; k <= 5; k++)
      beat(32'(k), 1'b0, 16'sd0, 5'd0, 1'b1, 10'd300,
           8'(k), 10'(300 + k - 1), (k <= 3));
    rst          = 1'b1;
    psum_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst.valid",  {31'd0, act_valid_o}, 32'd0);
    check("midrst.result", {24'd0, act_result_o}, 32'd0);
    check("midrst.addr",   {22'd0, act_result_address_o}, 32'd0);
    beat(32'sd7, 1'b0, 16'sd0, 5'd0, 1'b1, 10'd0, 8'd7, 10'd0, 1'b1);
    beat(32'sd8, 1'b1, 16'sd0, 5'd0, 1'b1, 10'd0, 8'd8, 10'd1, 1'b1);
    drain_compare("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/activation_unit.md
ACTIVATION_UNIT -- requirements
Module: activation_unit

Interface
REQ-001 SHALL have parameter PSUM_W, default 32, giving the signed partial-sum input width.
REQ-002 SHALL have parameter SHIFT_W, default 5, giving the requantization shift-amount width.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 psum_valid_i  input  1  qualifies the psum_i and psum_last_i beat.
REQ-006 psum_i  input  PSUM_W  signed accumulated partial sum.
REQ-007 psum_last_i  input  1  marks the final beat of a frame; meaningful only while psum_valid_i=1.
REQ-008 bias_i  input  16  signed per-channel bias.
REQ-009 shift_i  input  SHIFT_W  unsigned arithmetic right-shift amount.
REQ-010 relu_en_i  input  1  1 = ReLU with unsigned 8-bit output; 0 = signed 8-bit output.
REQ-011 base_addr_i  input  10  address assigned to the first beat of a frame.
REQ-012 act_valid_o  output  1  qualifies the act_* outputs of the downstream pooling stage.
REQ-013 act_result_o  output  8  requantized activation.
REQ-014 act_result_address_o  output  10  buffer address of act_result_o.
REQ-015 act_last_o  output  1  final beat of a frame.

Function
REQ-016 SHALL have no backpressure: every beat with psum_valid_i=1 SHALL be accepted.
REQ-017 SHALL use a two-stage pipeline with a fixed latency of 2 cycles from an accepted beat to its act_valid_o=1 cycle.
REQ-018 SHALL keep beat order, and SHALL NOT produce an output for a cycle with psum_valid_i=0.
REQ-019 SHALL implement a frame FSM with two states.
- IDLE: an accepted beat with psum_last_i=0 moves the FSM to BUSY.
- IDLE: an accepted beat with psum_last_i=1 is a single-beat frame, and the FSM stays in IDLE.
- BUSY: an accepted beat with psum_last_i=1 returns the FSM to IDLE.
- BUSY: any other input holds the FSM in BUSY.
REQ-020 In IDLE, SHALL latch bias_i, shift_i, relu_en_i and base_addr_i on an accepted beat.
- That beat and every later beat of the same frame SHALL use the latched values.
- Input changes while in BUSY SHALL be ignored.
REQ-021 Stage 1 SHALL form sum = psum_i + sign-extended bias, at width PSUM_W+1, with no overflow possible.
REQ-022 Stage 2 rounding and shift: if shift=0, r = sum; otherwise r = (sum + 2^(shift-1)) arithmetically shifted right by shift (round half up).
REQ-023 Stage 2 output with relu_en=1: act_result_o = 0 if r<0, 255 if r>255, else r.
REQ-024 Stage 2 output with relu_en=0: act_result_o = two's-complement r saturated to [-128, 127].
REQ-025 Address of a beat SHALL be (latched base + in-frame index) mod 1024.
- The index SHALL be 0 on the first beat of a frame and SHALL increment only on accepted beats.
- The address SHALL wrap from 1023 to 0 with no flag.
REQ-026 SHALL delay act_last_o with the beat that carried psum_last_i=1, and SHALL assert it only while act_valid_o=1.
REQ-027 After a last beat, the next accepted beat SHALL start a new frame; a valid beat on the cycle right after last is allowed, with no bubble required.
REQ-028 While act_valid_o=0, act_result_o and act_result_address_o SHALL hold their previous values.

Reset
REQ-029 On rst=1 at a clock edge, all of the following SHALL clear:
- FSM state to IDLE and in-frame index to 0.
- Latched config and both pipeline stages.
- All outputs to 0: act_valid_o, act_last_o, act_result_o, act_result_address_o.
REQ-030 A reset in mid-frame SHALL drop any beats in flight.
- No act_valid_o=1 SHALL appear for beats accepted before the reset.
- The first accepted beat after reset SHALL start a new frame.

Verification
REQ-031 Requantization, relu_en=1, one beat each:
- psum 1000, bias 24, shift 2 -> 255 (saturated).
- psum 20, bias 0, shift 3 -> 3.
- psum -50, bias 0, shift 0 -> 0.
REQ-032 Signed output, relu_en=0, shift 0:
- psum -50 -> 0xCE.
- psum -300 -> 0x80.
- psum 300 -> 0x7F.
REQ-033 Frame addressing: base 1, 16 back-to-back beats, last on beat 16 -> addresses 1..16; act_last_o=1 only with address 16; each output 2 cycles after its input.
REQ-034 Wrap and bubbles: base 1020, 6 beats with psum_valid_i=0 gaps -> addresses 1020, 1021, 1022, 1023, 0, 1; no outputs during the gaps.
REQ-035 Config isolation: change base_addr_i and shift_i in mid-frame -> the current frame is unaffected; the next frame, sent back-to-back after last, uses the new values, starting at the new base.
REQ-036 Reset mid-frame: assert rst 1 cycle after beat 5 of 16 -> no output for beats 4-5; a new frame with base 0 gives address 0 first.
